fmultiplier: RTL and testbench



---
 rtl/fp32_pkg.sv | 32 +++
 rtl/fp32_round_pack.sv | 54 +++++
 rtl/fmultiplier.sv | 110 +++++++++++
 tb/tb_fmultiplier.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 field widths, constants and operand classification
// for the floating-point datapath blocks.
`timescale 1ns/1ps
package fp32_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = 127;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_class_e;

  // Subnormals classify as zero: the fraction is ignored whenever exp=0.
  function automatic fp_class_e classify(input logic [EXP_W-1:0] exp,
                                         input logic [FRAC_W-1:0] frac);
    fp_class_e cls;
    if (exp == '0)
      cls = ZERO;
    else if (exp == '1)
      cls = (frac == '0) ? INF : NAN;
    else
      cls = NORM;
    return cls;
  endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Normalises a 48-bit significand product, rounds to nearest-even and packs
// a binary32 result, saturating to inf on overflow and flushing to zero below.
`timescale 1ns/1ps
module fp32_round_pack
  import fp32_pkg::*;
(
  input  logic               sign,
  input  logic signed [9:0]  exp,
  input  logic [47:0]        prod,
  output logic [31:0]        z
);

  logic [FRAC_W-1:0]  mant;
  logic               guard;
  logic               sticky;
  logic signed [9:0]  exp_n;
  logic [FRAC_W:0]    mant_r;
  logic signed [9:0]  exp_r;

  function automatic logic rne_up(input logic lsb, input logic g, input logic s);
    return g & (s | lsb);
  endfunction

  always_comb begin
    mant   = prod[45:23];
    guard  = prod[22];
    sticky = |prod[21:0];
    exp_n  = exp;
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_n  = exp + 10'sd1;
    end
  end

  // A carry out of the rounded mantissa leaves the fraction at zero and bumps the exponent.
  always_comb begin
    mant_r = {1'b0, mant} + {{FRAC_W{1'b0}}, rne_up(mant[0], guard, sticky)};
    exp_r  = exp_n;
    if (mant_r[FRAC_W])
      exp_r = exp_n + 10'sd1;
  end

  always_comb begin
    if (exp_r >= 10'sd255)
      z = {sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    else if (exp_r <= 10'sd0)
      z = {sign, {(EXP_W+FRAC_W){1'b0}}};
    else
      z = {sign, exp_r[EXP_W-1:0], mant_r[FRAC_W-1:0]};
  end

endmodule

// File: rtl/fmultiplier.sv
// Three-stage pipelined binary32 multiplier, RNE rounding, flush-to-zero,
// one operand pair per cycle with a fixed two-edge input-to-output latency.
`timescale 1ns/1ps
module fmultiplier
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z
);

  localparam logic signed [9:0] BIAS_S = 10'(BIAS);

  fp_class_e cls_a;
  fp_class_e cls_b;
  fp_class_e cls_res;

  logic              sign_p0;
  fp_class_e         cls_p0;
  logic [EXP_W-1:0]  exp_a_p0;
  logic [EXP_W-1:0]  exp_b_p0;
  logic [FRAC_W:0]   man_a_p0;
  logic [FRAC_W:0]   man_b_p0;

  logic              sign_p1;
  fp_class_e         cls_p1;
  logic signed [9:0] exp_p1;
  logic [47:0]       prod_p1;

  logic signed [9:0] exp_sum;
  logic [47:0]       prod;
  logic [31:0]       norm_z;

  assign cls_a = classify(a[30:23], a[22:0]);
  assign cls_b = classify(b[30:23], b[22:0]);

  // Special-result priority: NaN operand, then inf*zero, then inf, then zero.
  always_comb begin
    cls_res = NORM;
    if (cls_a == NAN || cls_b == NAN)
      cls_res = NAN;
    else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF))
      cls_res = NAN;
    else if (cls_a == INF || cls_b == INF)
      cls_res = INF;
    else if (cls_a == ZERO || cls_b == ZERO)
      cls_res = ZERO;
  end

  // Stage 1: unpacked fields and result class
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_p0  <= 1'b0;
      cls_p0   <= ZERO;
      exp_a_p0 <= '0;
      exp_b_p0 <= '0;
      man_a_p0 <= '0;
      man_b_p0 <= '0;
    end else begin
      sign_p0  <= a[31] ^ b[31];
      cls_p0   <= cls_res;
      exp_a_p0 <= a[30:23];
      exp_b_p0 <= b[30:23];
      man_a_p0 <= {1'b1, a[22:0]};
      man_b_p0 <= {1'b1, b[22:0]};
    end
  end

  assign exp_sum = $signed({2'b00, exp_a_p0}) + $signed({2'b00, exp_b_p0}) - BIAS_S;
  assign prod    = {24'b0, man_a_p0} * {24'b0, man_b_p0};

  // Stage 2: significand product, exponent sum, sign
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_p1 <= 1'b0;
      cls_p1  <= ZERO;
      exp_p1  <= '0;
      prod_p1 <= '0;
    end else begin
      sign_p1 <= sign_p0;
      cls_p1  <= cls_p0;
      exp_p1  <= exp_sum;
      prod_p1 <= prod;
    end
  end

  fp32_round_pack u_round_pack (
    .sign (sign_p1),
    .exp  (exp_p1),
    .prod (prod_p1),
    .z    (norm_z)
  );

  // Stage 3: select special or rounded result into z
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z <= '0;
    end else begin
      case (cls_p1)
        NAN:     z <= QNAN;
        INF:     z <= {sign_p1, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        ZERO:    z <= {sign_p1, {(EXP_W+FRAC_W){1'b0}}};
        default: z <= norm_z;
      endcase
    end
  end

endmodule

// File: tb/tb_fmultiplier.sv
// Scoreboard bench for fmultiplier: directed vectors push expected products,
// a negedge monitor pops and compares when its latency tracker says z is due.
`timescale 1ns/1ps
module tb_fmultiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] z;

  int total = 0;
  int bad   = 0;

  logic [31:0] expq[$];
  int          idxq[$];
  int          vec_id = 0;
  logic        iss = 1'b0;
  logic [2:0]  due;

  always #5 clk = ~clk;

  fmultiplier dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .z   (z)
  );

  // Bench-side latency model: a pair sampled at edge N is due after edge N+2.
  always @(posedge clk or posedge rst) begin
    if (rst) due <= 3'b000;
    else     due <= {due[1:0], iss};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: z=%08h expected=%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && due[2]) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: z=%08h expected=none", z);
      end else begin
        check($sformatf("vec%0d", idxq.pop_front()), z, expq.pop_front());
      end
    end
  end

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [31:0] e);
    @(negedge clk);
    a   = x;
    b   = y;
    iss = 1'b1;
    expq.push_back(e);
    idxq.push_back(vec_id);
    vec_id++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      iss = 1'b0;
      a   = 32'h0;
      b   = 32'h0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: z=%08h expected=finish", z);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    a   = 32'h0;
    b   = 32'h0;
    #12;
    check("reset_z", z, 32'h0);
    #1 rst = 1'b0;

    // Latency, hold-stable, basic and sign
    issue(32'h3E99999A, 32'h3E99999A, 32'h3DB851EC);
    issue(32'h3E99999A, 32'h3E99999A, 32'h3DB851EC);
    issue(32'h40000000, 32'h40400000, 32'h40C00000);
    issue(32'hBFC00000, 32'h40000000, 32'hC0400000);
    // Rounding
    issue(32'h3F800001, 32'h3F800001, 32'h3F800002);
    issue(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);
    // Specials
    issue(32'h7F800000, 32'h00000000, 32'h7FC00000);
    issue(32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    issue(32'hFF800000, 32'h40000000, 32'hFF800000);
    issue(32'h80000000, 32'h40000000, 32'h80000000);
    // Overflow, underflow, FTZ
    issue(32'h7F000000, 32'h7F000000, 32'h7F800000);
    issue(32'h00800000, 32'h00800000, 32'h00000000);
    issue(32'h00000001, 32'h3F800000, 32'h00000000);
    idle(4);

    // Asynchronous reset with operations in flight
    issue(32'h40000000, 32'h40400000, 32'h40C00000);
    issue(32'hBFC00000, 32'h40000000, 32'hC0400000);
    issue(32'h3F800001, 32'h3F800001, 32'h3F800002);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst_z", z, 32'h0);
    expq.delete();
    idxq.delete();
    iss = 1'b0;
    a   = 32'h0;
    b   = 32'h0;
    @(negedge clk);
    check("rst_hold_z", z, 32'h0);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("no_stale", z, 32'h0);
    end

    // Pipeline operates normally after reset
    issue(32'h40000000, 32'h40400000, 32'h40C00000);
    issue(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE);
    idle(5);

    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected=0", expq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
